// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the RV32I hazard controller: operand-forward selects and bus-wait FSM states.
package pipe_hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  // Wide enough for any bus timeout up to 255 cycles.
  localparam int WAIT_W = 8;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: stage register info in, stall/flush/forward controls out.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [4:0]       ex_wR;
  logic             ex_rf_we;
  logic             ex_is_load;
  logic             ex_redirect;
  logic [4:0]       mem_wR;
  logic             mem_rf_we;
  logic             mem_req;
  logic             bus_ready;
  logic [4:0]       wb_wR;
  logic             wb_rf_we;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             pc_stall;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             pipe_freeze;
  logic             bus_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    output ex_wR, ex_rf_we, ex_is_load, ex_redirect,
    output mem_wR, mem_rf_we, mem_req, bus_ready,
    output wb_wR, wb_rf_we,
    input  fwd_a, fwd_b, pc_stall, if_id_stall, if_id_flush, id_ex_flush,
    input  pipe_freeze, bus_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    input  ex_wR, ex_rf_we, ex_is_load, ex_redirect,
    input  mem_wR, mem_rf_we, mem_req, bus_ready,
    input  wb_wR, wb_rf_we,
    output fwd_a, fwd_b, pc_stall, if_id_stall, if_id_flush, id_ex_flush,
    output pipe_freeze, bus_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Priority forward select for one EX operand (EX > MEM > WB > regfile); also flags a raw EX match.
module pipe_hazard_ctrl_fwd_sel
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs,
  input  logic       rs_used,
  input  logic [4:0] ex_wR,
  input  logic       ex_rf_we,
  input  logic       ex_is_load,
  input  logic [4:0] mem_wR,
  input  logic       mem_rf_we,
  input  logic [4:0] wb_wR,
  input  logic       wb_rf_we,
  output logic [1:0] sel,
  output logic       ex_hit
);
  logic rs_live;
  logic mem_hit;
  logic wb_hit;

  assign rs_live = rs_used & (rs != 5'd0);
  assign ex_hit  = rs_live & ex_rf_we  & (ex_wR  == rs);
  assign mem_hit = rs_live & mem_rf_we & (mem_wR == rs);
  assign wb_hit  = rs_live & wb_rf_we  & (wb_wR  == rs);

  // A load in EX has no data yet; the load-use bubble handles it, so fall through to older stages.
  always_comb begin
    sel = FWD_RF;
    if (ex_hit && !ex_is_load) sel = FWD_EX;
    else if (mem_hit)          sel = FWD_MEM;
    else if (wb_hit)           sel = FWD_WB;
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller: forwarding, load-use bubbles, redirect flushes and bus-wait freeze with watchdog.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int BUS_TIMEOUT = 16
) (
  input logic               cpu_clk,
  input logic               cpu_rst,
  pipe_hazard_ctrl_if.slave hz
);
  localparam logic [WAIT_W-1:0] TIMEOUT = WAIT_W'(BUS_TIMEOUT);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              err_set;
  logic              freeze;
  logic              hit_a, hit_b;
  logic              load_hz;
  logic              bus_err;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  pipe_hazard_ctrl_fwd_sel u_fwd_a (
    .rs(hz.id_rs1), .rs_used(hz.id_rs1_used),
    .ex_wR(hz.ex_wR), .ex_rf_we(hz.ex_rf_we), .ex_is_load(hz.ex_is_load),
    .mem_wR(hz.mem_wR), .mem_rf_we(hz.mem_rf_we),
    .wb_wR(hz.wb_wR), .wb_rf_we(hz.wb_rf_we),
    .sel(hz.fwd_a), .ex_hit(hit_a)
  );

  pipe_hazard_ctrl_fwd_sel u_fwd_b (
    .rs(hz.id_rs2), .rs_used(hz.id_rs2_used),
    .ex_wR(hz.ex_wR), .ex_rf_we(hz.ex_rf_we), .ex_is_load(hz.ex_is_load),
    .mem_wR(hz.mem_wR), .mem_rf_we(hz.mem_rf_we),
    .wb_wR(hz.wb_wR), .wb_rf_we(hz.wb_rf_we),
    .sel(hz.fwd_b), .ex_hit(hit_b)
  );

  assign load_hz = hz.ex_is_load & (hit_a | hit_b);

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    err_set   = 1'b0;
    freeze    = 1'b0;
    case (state)
      ST_RUN: begin
        if (hz.mem_req && !hz.bus_ready) begin
          freeze    = 1'b1;
          state_nxt = ST_WAIT;
          wait_nxt  = WAIT_W'(1);
        end
      end
      ST_WAIT: begin
        if (hz.bus_ready) begin
          state_nxt = ST_RUN;
        end else if (wait_cnt >= TIMEOUT) begin
          state_nxt = ST_RUN;
          err_set   = 1'b1;
        end else begin
          freeze   = 1'b1;
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Freeze dominates; a redirect squashes the wrong-path ID instruction, so it cancels the load-use stall.
  assign hz.pc_stall    = freeze | (~hz.ex_redirect & load_hz);
  assign hz.if_id_stall = freeze | (~hz.ex_redirect & load_hz);
  assign hz.if_id_flush = ~freeze & hz.ex_redirect;
  assign hz.id_ex_flush = ~freeze & (hz.ex_redirect | load_hz);
  assign hz.pipe_freeze = freeze;
  assign hz.bus_err     = bus_err;
  assign hz.stall_cnt   = stall_cnt;
  assign hz.flush_cnt   = flush_cnt;

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state     <= ST_RUN;
      wait_cnt  <= '0;
      bus_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (err_set)                     bus_err   <= 1'b1;
      if (hz.pc_stall)                 stall_cnt <= stall_cnt + CNT_W'(1);
      if (hz.ex_redirect && !freeze)   flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl with hand-computed expectations.
module tb_pipe_hazard_ctrl;
  localparam int CNT_W       = 32;
  localparam int BUS_TIMEOUT = 16;

  logic cpu_clk = 1'b0;
  logic cpu_rst = 1'b0;
  int   n_chk   = 0;
  int   n_fail  = 0;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .BUS_TIMEOUT(BUS_TIMEOUT)) dut (
    .cpu_clk(cpu_clk),
    .cpu_rst(cpu_rst),
    .hz(hz.slave)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    hz.id_rs1 = 5'd0; hz.id_rs2 = 5'd0; hz.id_rs1_used = 1'b0; hz.id_rs2_used = 1'b0;
    hz.ex_wR = 5'd0; hz.ex_rf_we = 1'b0; hz.ex_is_load = 1'b0; hz.ex_redirect = 1'b0;
    hz.mem_wR = 5'd0; hz.mem_rf_we = 1'b0; hz.mem_req = 1'b0; hz.bus_ready = 1'b0;
    hz.wb_wR = 5'd0; hz.wb_rf_we = 1'b0;
  endtask

  // Advance one clock and land just after the edge so new inputs and sampled state settle.
  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    cpu_rst = 1'b1;
    tick();
    cpu_rst = 1'b0;
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_fwd_a"},  32'(hz.fwd_a), 0);
    check_eq({tag, "_fwd_b"},  32'(hz.fwd_b), 0);
    check_eq({tag, "_ctl"},    32'({hz.pc_stall, hz.if_id_stall, hz.if_id_flush, hz.id_ex_flush, hz.pipe_freeze}), 0);
    check_eq({tag, "_bus_err"}, 32'(hz.bus_err), 0);
    check_eq({tag, "_stall"},  hz.stall_cnt, 0);
    check_eq({tag, "_flush"},  hz.flush_cnt, 0);
  endtask

  initial begin
    idle();
    cpu_rst = 1'b1;
    #12;
    check_all_zero("reset");
    @(negedge cpu_clk);
    cpu_rst = 1'b0;
    tick();

    // EX add x5 feeds rs1
    hz.id_rs1 = 5'd5; hz.id_rs1_used = 1'b1; hz.id_rs2 = 5'd3; hz.id_rs2_used = 1'b1;
    hz.ex_wR = 5'd5; hz.ex_rf_we = 1'b1;
    #1;
    check_eq("ex_fwd_a", 32'(hz.fwd_a), 1);
    check_eq("ex_fwd_b", 32'(hz.fwd_b), 0);
    check_eq("ex_no_stall", 32'(hz.pc_stall), 0);
    tick();
    check_eq("ex_stall_cnt", hz.stall_cnt, 0);

    // Load-use on rs2: one bubble, then MEM forward
    idle();
    hz.id_rs1 = 5'd1; hz.id_rs1_used = 1'b1; hz.id_rs2 = 5'd6; hz.id_rs2_used = 1'b1;
    hz.ex_wR = 5'd6; hz.ex_rf_we = 1'b1; hz.ex_is_load = 1'b1;
    #1;
    check_eq("lu_pc_stall", 32'(hz.pc_stall), 1);
    check_eq("lu_if_id_stall", 32'(hz.if_id_stall), 1);
    check_eq("lu_id_ex_flush", 32'(hz.id_ex_flush), 1);
    check_eq("lu_if_id_flush", 32'(hz.if_id_flush), 0);
    check_eq("lu_fwd_b_not_ex", 32'(hz.fwd_b), 0);
    tick();
    check_eq("lu_stall_cnt", hz.stall_cnt, 1);
    hz.ex_wR = 5'd0; hz.ex_rf_we = 1'b0; hz.ex_is_load = 1'b0;
    hz.mem_wR = 5'd6; hz.mem_rf_we = 1'b1;
    #1;
    check_eq("lu_next_fwd_b", 32'(hz.fwd_b), 2);
    check_eq("lu_next_pc_stall", 32'(hz.pc_stall), 0);
    check_eq("lu_next_id_ex_flush", 32'(hz.id_ex_flush), 0);
    tick();
    check_eq("lu_stall_cnt_hold", hz.stall_cnt, 1);

    // Forward priority and x0 handling
    idle();
    hz.id_rs1 = 5'd0; hz.id_rs1_used = 1'b1;
    hz.ex_rf_we = 1'b1; hz.mem_rf_we = 1'b1; hz.wb_rf_we = 1'b1;
    #1;
    check_eq("x0_fwd_a", 32'(hz.fwd_a), 0);
    hz.id_rs1 = 5'd7; hz.ex_wR = 5'd7; hz.mem_wR = 5'd7;
    #1;
    check_eq("ex_over_mem", 32'(hz.fwd_a), 1);
    hz.ex_wR = 5'd2; hz.mem_wR = 5'd9; hz.wb_wR = 5'd9; hz.id_rs1 = 5'd9;
    #1;
    check_eq("mem_over_wb", 32'(hz.fwd_a), 2);
    hz.mem_wR = 5'd4;
    #1;
    check_eq("wb_only", 32'(hz.fwd_a), 3);
    hz.id_rs1_used = 1'b0;
    #1;
    check_eq("rs1_unused", 32'(hz.fwd_a), 0);
    hz.id_rs2 = 5'd4; hz.id_rs2_used = 1'b1; hz.wb_wR = 5'd4;
    #1;
    check_eq("mem_over_wb_b", 32'(hz.fwd_b), 2);
    hz.mem_rf_we = 1'b0;
    #1;
    check_eq("wb_only_b", 32'(hz.fwd_b), 3);

    // Redirect overrides load-use
    idle();
    tick();
    hz.id_rs2 = 5'd6; hz.id_rs2_used = 1'b1;
    hz.ex_wR = 5'd6; hz.ex_rf_we = 1'b1; hz.ex_is_load = 1'b1; hz.ex_redirect = 1'b1;
    #1;
    check_eq("rd_if_id_flush", 32'(hz.if_id_flush), 1);
    check_eq("rd_id_ex_flush", 32'(hz.id_ex_flush), 1);
    check_eq("rd_pc_stall", 32'(hz.pc_stall), 0);
    check_eq("rd_if_id_stall", 32'(hz.if_id_stall), 0);
    tick();
    check_eq("rd_flush_cnt", hz.flush_cnt, 1);
    check_eq("rd_stall_cnt", hz.stall_cnt, 1);

    // Bus wait of 3 cycles, with a redirect held across the freeze
    do_reset();
    hz.mem_req = 1'b1;
    #1;
    check_eq("bw_freeze_1", 32'(hz.pipe_freeze), 1);
    check_eq("bw_pc_stall_1", 32'(hz.pc_stall), 1);
    tick();
    hz.ex_redirect = 1'b1;
    #1;
    check_eq("bw_freeze_2", 32'(hz.pipe_freeze), 1);
    check_eq("bw_frz_if_id_flush", 32'(hz.if_id_flush), 0);
    check_eq("bw_frz_id_ex_flush", 32'(hz.id_ex_flush), 0);
    check_eq("bw_frz_if_id_stall", 32'(hz.if_id_stall), 1);
    tick();
    check_eq("bw_freeze_3", 32'(hz.pipe_freeze), 1);
    check_eq("bw_frz_flush_cnt", hz.flush_cnt, 0);
    tick();
    hz.bus_ready = 1'b1;
    #1;
    check_eq("bw_ready_freeze", 32'(hz.pipe_freeze), 0);
    check_eq("bw_ready_pc_stall", 32'(hz.pc_stall), 0);
    check_eq("bw_ready_if_id_flush", 32'(hz.if_id_flush), 1);
    tick();
    idle();
    #1;
    check_eq("bw_stall_cnt", hz.stall_cnt, 3);
    check_eq("bw_flush_cnt", hz.flush_cnt, 1);
    check_eq("bw_bus_err", 32'(hz.bus_err), 0);
    check_eq("bw_idle_freeze", 32'(hz.pipe_freeze), 0);

    // Timeout: 16 frozen cycles, then release with bus_err
    do_reset();
    hz.mem_req = 1'b1;
    for (int i = 0; i < BUS_TIMEOUT; i++) begin
      #1;
      check_eq($sformatf("to_freeze_%0d", i), 32'(hz.pipe_freeze), 1);
      tick();
    end
    #1;
    check_eq("to_release_freeze", 32'(hz.pipe_freeze), 0);
    check_eq("to_err_not_yet", 32'(hz.bus_err), 0);
    hz.mem_req = 1'b0;
    tick();
    check_eq("to_bus_err", 32'(hz.bus_err), 1);
    check_eq("to_stall_cnt", hz.stall_cnt, BUS_TIMEOUT);
    // FSM back in RUN: a fresh miss must freeze at once
    hz.mem_req = 1'b1;
    #1;
    check_eq("to_rerun_freeze", 32'(hz.pipe_freeze), 1);
    tick();
    hz.bus_ready = 1'b1;
    #1;
    check_eq("to_rerun_ready", 32'(hz.pipe_freeze), 0);
    tick();
    idle();
    tick();
    check_eq("to_err_sticky", 32'(hz.bus_err), 1);

    // Asynchronous reset mid-wait
    hz.mem_req = 1'b1;
    tick();
    tick();
    #1;
    check_eq("mr_waiting", 32'(hz.pipe_freeze), 1);
    @(negedge cpu_clk);
    idle();
    cpu_rst = 1'b1;
    #1;
    check_all_zero("mid_rst");
    cpu_rst = 1'b0;
    tick();
    hz.mem_req = 1'b1;
    #1;
    check_eq("mr_run_freeze", 32'(hz.pipe_freeze), 1);
    hz.bus_ready = 1'b1;
    #1;
    check_eq("mr_run_ready", 32'(hz.pipe_freeze), 0);
    tick();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
